// File: rtl/adder_8_seq_ctrl.sv
// adder_8_seq_ctrl: sequential W-bit adder that reuses one external 8-bit adder, one byte per cycle.
//
// Ports:
//   clk_i, rst_i           single clock; synchronous active-high reset
//   start_i                operation request, sampled only in IDLE
//   op_a_i, op_b_i         W-bit operands (W = 8*NBYTES), captured on an accepted start
//   cin_i                  carry-in for byte 0, captured on an accepted start
//   sub_i                  subtract request, captured on an accepted start (used only with the
//                          macro below; otherwise ignored)
//   add_a_o, add_b_o       operand bytes driven to the external 8-bit adder (0 outside RUN)
//   add_cin_o              carry driven to the external adder (0 outside RUN)
//   add_sum_i, add_cout_i  combinational sum / carry-out returned by the external adder
//   busy_o                 high exactly in RUN
//   done_o                 one-cycle completion pulse (DONE state)
//   result_o, cout_o       W-bit result and final carry, held until the next accepted start
//   ovf_o                  signed overflow of the final byte
//
// Build option: define ADDER_8_SEQ_SUB_EN to enable subtraction (op_a - op_b, cout=1 = no borrow).

module adder_8_seq_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [8*NBYTES-1:0]   op_a_i,
    input  logic [8*NBYTES-1:0]   op_b_i,
    input  logic                  cin_i,
    input  logic                  sub_i,
    output logic [7:0]            add_a_o,
    output logic [7:0]            add_b_o,
    output logic                  add_cin_o,
    input  logic [7:0]            add_sum_i,
    input  logic                  add_cout_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [8*NBYTES-1:0]   result_o,
    output logic                  cout_o,
    output logic                  ovf_o
);

    localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

`ifdef ADDER_8_SEQ_SUB_EN
    localparam logic SubEn = 1'b1;
`else
    localparam logic SubEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic                    sub_q, sub_d;
    logic                    cout_q, cout_d;
    logic                    ovf_q, ovf_d;
    logic [NBYTES-1:0][7:0]  a_q, a_d;
    logic [NBYTES-1:0][7:0]  b_q, b_d;
    logic [NBYTES-1:0][7:0]  result_q, result_d;
    logic                    sub_eff;

    // With the feature disabled sub_eff is constant 0, so sub_i has no effect.
    assign sub_eff = sub_i & SubEn;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            sub_q    <= sub_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        sub_d     = sub_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        add_a_o   = 8'h00;
        add_b_o   = 8'h00;
        add_cin_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    sub_d   = sub_eff;
                    idx_d   = '0;
                    // Subtraction is a + ~b + 1, so the initial carry is forced high.
                    carry_d = sub_eff ? 1'b1 : cin_i;
                    state_d = StRun;
                end
            end
            StRun: begin
                add_a_o          = a_q[idx_q];
                add_b_o          = b_q[idx_q] ^ {8{sub_q}};
                add_cin_o        = carry_q;
                result_d[idx_q]  = add_sum_i;
                carry_d          = add_cout_i;
                idx_d            = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    cout_d  = add_cout_i;
                    // Carry into bit 7 is recovered from the sum: a ^ b ^ s.
                    ovf_d   = (add_a_o[7] ^ add_b_o[7] ^ add_sum_i[7]) ^ add_cout_i;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy_o   = (state_q == StRun);
    assign done_o   = (state_q == StDone);
    assign result_o = result_q;
    assign cout_o   = cout_q;
    assign ovf_o    = ovf_q;

endmodule

// File: doc/adder_8_seq_ctrl.md
ADDER_8_SEQ_CTRL -- requirements
Module: adder_8_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, giving the operand width in bytes (W = 8*NBYTES), legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, operation request, sampled only in IDLE.
REQ-005 The block SHALL have ports op_a and op_b, input, W each, the operands, captured on an accepted start.
REQ-006 The block SHALL have port cin, input, 1, carry-in for byte 0, captured on an accepted start.
REQ-007 The block SHALL have port sub, input, 1, subtract request, captured on an accepted start (see Configuration).
REQ-008 The block SHALL have ports add_a and add_b, output, 8 each, operand bytes driven to the external 8-bit adder.
REQ-009 The block SHALL have port add_cin, output, 1, carry driven to the external adder.
REQ-010 The block SHALL have port add_sum, input, 8, combinational sum returned by the external adder.
REQ-011 The block SHALL have port add_cout, input, 1, combinational carry-out returned by the external adder.
REQ-012 The block SHALL have ports busy (output, 1, high in RUN), done (output, 1, one-cycle completion pulse), result (output, W), cout (output, 1, final carry) and ovf (output, 1, signed overflow).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 In IDLE with start=1, the block SHALL latch op_a, op_b, cin and sub, clear byte index to 0, set the carry register to the latched carry-in, and enter RUN.
REQ-015 In RUN, each cycle SHALL drive add_a/add_b with byte[idx] of the latched operands and add_cin with the carry register, then write add_sum into result byte[idx] and add_cout into the carry register at the clock edge.
REQ-016 The byte index SHALL increment once per RUN cycle; the transition RUN->DONE SHALL occur on the edge that processes byte NBYTES-1 (no wrap-around into byte 0).
REQ-017 In DONE, done=1 for exactly one cycle and the next state SHALL be IDLE unconditionally.
REQ-018 Latency SHALL be fixed: start sampled at edge k, done high during the cycle after edge k+NBYTES.
REQ-019 cout SHALL equal the final carry register; ovf SHALL equal (carry into MSB) XOR (carry out of MSB), captured at the last RUN edge.
REQ-020 result, cout and ovf SHALL hold their values from DONE until the next accepted start, and SHALL update only during RUN.
REQ-021 start in RUN or DONE SHALL be ignored (no queueing); start must be re-asserted in IDLE.
REQ-022 Outside RUN, add_a, add_b and add_cin SHALL be driven to 0.
REQ-023 busy SHALL be 1 exactly in RUN; busy and done SHALL never be high together.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, with busy=0, done=0, result=0, cout=0, ovf=0, index=0 and carry register=0, overriding any other input.
REQ-025 rst asserted mid-RUN SHALL abort the operation with no done pulse; a start in the first cycle after rst deasserts SHALL be accepted normally.

Configuration
REQ-026 With macro ADDER_8_SEQ_SUB_EN defined, sub=1 at start SHALL invert every op_b byte driven on add_b and force the initial carry to 1 (cin ignored), yielding op_a - op_b; cout=1 means no borrow.
REQ-027 Without ADDER_8_SEQ_SUB_EN, sub SHALL be ignored, the port SHALL remain present, and operation SHALL always be op_a + op_b + cin.

Verification (NBYTES=4, external adder modelled as the team's 8-bit structural adder)
REQ-028 op_a=0x000000FF, op_b=0x00000001, cin=0, start one cycle -> result=0x00000100, cout=0, ovf=0, done exactly 5 cycles after start sampled, busy high 4 cycles.
REQ-029 op_a=0xFFFFFFFF, op_b=0x00000001, cin=0 -> result=0x00000000, cout=1, ovf=0; op_a=0x7FFFFFFF, op_b=0x00000001 -> result=0x80000000, cout=0, ovf=1.
REQ-030 start held high continuously with changing operands -> each accepted op takes NBYTES+2 cycles start-to-start; operands changed during RUN do not affect result.
REQ-031 rst pulsed in the second RUN cycle -> no done pulse, all outputs 0 next cycle; following op 0x12345678+0x11111111, cin=1 -> 0x2345678A.
REQ-032 With ADDER_8_SEQ_SUB_EN: op_a=5, op_b=7, sub=1 -> result=0xFFFFFFFE, cout=0; op_a=7, op_b=5, sub=1 -> result=0x00000002, cout=1; without macro the same stimulus gives 0x0000000C and 0x0000000C.
